// File: rtl/pkt_seg_writer.sv
// pkt_seg_writer
//   Front end of the parser segment RAM. Accepts a packet on an AXI-Stream
//   slave port, writes the first SEG_NUM beats (keep-masked) into the segment
//   RAM write port and zero-pads short packets up to SEG_NUM entries. After
//   each segment set it pulses o_wait_segs_end for one cycle so the parser can
//   flip RAM banks. Every beat is also forwarded unchanged through a one-stage
//   registered AXI-Stream master port. A credit counter tracks free RAM banks
//   so a new packet is only started when a bank is free.
//
// Ports
//   axis_clk, areset          clock, asynchronous active-high reset
//   s_axis_*                  packet input (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_*                  registered packet output
//   o_seg_tdata/wea/addra     segment RAM write port (one write per cycle)
//   o_wait_segs_end           one-cycle pulse after the last segment write
//   i_parser_done             one-cycle pulse: parser released a bank
//   o_credits                 number of free banks (0..BANKS)
//   o_credit_err              sticky: release seen while all banks were free
module pkt_seg_writer #(
  parameter int DATA_WIDTH = 256,
  parameter int SEG_NUM    = 8,
  parameter int SEG_ADDR_W = 3,
  parameter int BANKS      = 2
) (
  input  logic                    axis_clk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   o_seg_tdata,
  output logic                    o_seg_wea,
  output logic [SEG_ADDR_W-1:0]   o_seg_addra,
  output logic                    o_wait_segs_end,
  input  logic                    i_parser_done,
  output logic [1:0]              o_credits,
  output logic                    o_credit_err
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam logic [SEG_ADDR_W-1:0] LAST_ADDR = SEG_ADDR_W'(SEG_NUM - 1);
  localparam logic [1:0] BANKS_C = 2'(BANKS);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_PAD, S_SEG_END, S_PASS
  } state_t;

  state_t                  state_q, state_d;
  logic [SEG_ADDR_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic                    last_seen_q, last_seen_d;
  logic                    seg_wea_q, seg_wea_d;
  logic [SEG_ADDR_W-1:0]   seg_addr_q, seg_addr_d;
  logic [DATA_WIDTH-1:0]   seg_data_q, seg_data_d;
  logic                    m_tvalid_q;
  logic [DATA_WIDTH-1:0]   m_tdata_q;
  logic [KEEP_W-1:0]       m_tkeep_q;
  logic                    m_tlast_q;
  logic                    wait_end_q;
  logic [1:0]              credits_q, credits_d;
  logic                    credit_err_q, credit_err_d;

  logic                    en;
  logic                    s_ready;
  logic                    acc;
  logic                    seg_end;
  logic [DATA_WIDTH-1:0]   masked_data;

  // Bytes with tkeep=0 are written to the segment RAM as zero.
  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_mask
    assign masked_data[gi*8 +: 8] = s_axis_tkeep[gi] ? s_axis_tdata[gi*8 +: 8] : 8'h00;
  end

  // Input is only enabled in states that consume beats; a new packet may
  // start only when a free bank exists.
  always_comb begin
    en = 1'b0;
    case (state_q)
      S_IDLE:            en = (credits_q != 2'd0);
      S_CAPTURE, S_PASS: en = 1'b1;
      default:           en = 1'b0;
    endcase
  end

  assign s_ready = (~m_tvalid_q | m_axis_tready) & en & ~areset;
  assign acc     = s_axis_tvalid & s_ready;
  assign seg_end = (state_q == S_SEG_END);

  always_comb begin
    state_d     = state_q;
    seg_cnt_d   = seg_cnt_q;
    last_seen_d = last_seen_q;
    seg_wea_d   = 1'b0;
    seg_addr_d  = seg_cnt_q;
    seg_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          seg_wea_d  = 1'b1;
          seg_addr_d = '0;
          seg_data_d = masked_data;
          seg_cnt_d  = SEG_ADDR_W'(1);
          state_d    = s_axis_tlast ? S_PAD : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (acc) begin
          seg_wea_d  = 1'b1;
          seg_data_d = masked_data;
          seg_cnt_d  = seg_cnt_q + SEG_ADDR_W'(1);
          if (seg_cnt_q == LAST_ADDR) begin
            state_d     = S_SEG_END;
            last_seen_d = s_axis_tlast;
          end else if (s_axis_tlast) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        // Fill the rest of the bank with zeros while input is stalled.
        seg_wea_d = 1'b1;
        seg_cnt_d = seg_cnt_q + SEG_ADDR_W'(1);
        if (seg_cnt_q == LAST_ADDR) begin
          state_d     = S_SEG_END;
          last_seen_d = 1'b1;
        end
      end
      S_SEG_END: begin
        seg_cnt_d = '0;
        state_d   = last_seen_q ? S_IDLE : S_PASS;
      end
      S_PASS: begin
        if (acc && s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A bank consumed and a bank released in the same cycle cancel out.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (seg_end && !i_parser_done) begin
      credits_d = credits_q - 2'd1;
    end else if (!seg_end && i_parser_done) begin
      if (credits_q == BANKS_C) credit_err_d = 1'b1;
      else                      credits_d    = credits_q + 2'd1;
    end
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      seg_cnt_q    <= '0;
      last_seen_q  <= 1'b0;
      seg_wea_q    <= 1'b0;
      seg_addr_q   <= '0;
      seg_data_q   <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      m_tlast_q    <= 1'b0;
      wait_end_q   <= 1'b0;
      credits_q    <= BANKS_C;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_cnt_q    <= seg_cnt_d;
      last_seen_q  <= last_seen_d;
      seg_wea_q    <= seg_wea_d;
      seg_addr_q   <= seg_addr_d;
      seg_data_q   <= seg_data_d;
      wait_end_q   <= seg_end;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      if (acc) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis_tdata;
        m_tkeep_q  <= s_axis_tkeep;
        m_tlast_q  <= s_axis_tlast;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign s_axis_tready   = s_ready;
  assign m_axis_tdata    = m_tdata_q;
  assign m_axis_tkeep    = m_tkeep_q;
  assign m_axis_tvalid   = m_tvalid_q;
  assign m_axis_tlast    = m_tlast_q;
  assign o_seg_tdata     = seg_data_q;
  assign o_seg_wea       = seg_wea_q;
  assign o_seg_addra     = seg_addr_q;
  assign o_wait_segs_end = wait_end_q;
  assign o_credits       = credits_q;
  assign o_credit_err    = credit_err_q;

endmodule

// File: tb/tb_pkt_seg_writer.sv
// tb_pkt_seg_writer
//   Scoreboard bench for pkt_seg_writer: expected m_axis beats and segment
//   writes are queued when a packet is driven and compared by monitors when
//   the DUT produces them. Scenario tasks cover reset, long/short packets,
//   credit exhaustion, coincident release, backpressure and mid-packet reset.
module tb_pkt_seg_writer;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int SN = 8;

  logic            axis_clk = 1'b0;
  logic            areset   = 1'b1;
  logic [DW-1:0]   s_axis_tdata  = '0;
  logic [KW-1:0]   s_axis_tkeep  = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tlast  = 1'b0;
  logic            s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready = 1'b1;
  logic [DW-1:0]   o_seg_tdata;
  logic            o_seg_wea;
  logic [2:0]      o_seg_addra;
  logic            o_wait_segs_end;
  logic            i_parser_done = 1'b0;
  logic [1:0]      o_credits;
  logic            o_credit_err;

  logic toggle_en = 1'b0;
  logic ready_val = 1'b1;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [2:0]    addr;
    logic [DW-1:0] data;
  } seg_t;

  beat_t m_q[$];
  seg_t  seg_q[$];
  beat_t mon_b;
  seg_t  mon_s;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;
  logic       prev_wea  = 1'b0;
  logic [2:0] prev_addr = '0;

  pkt_seg_writer #(
    .DATA_WIDTH(DW), .SEG_NUM(SN), .SEG_ADDR_W(3), .BANKS(2)
  ) dut (
    .axis_clk(axis_clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .o_seg_tdata(o_seg_tdata), .o_seg_wea(o_seg_wea), .o_seg_addra(o_seg_addra),
    .o_wait_segs_end(o_wait_segs_end), .i_parser_done(i_parser_done),
    .o_credits(o_credits), .o_credit_err(o_credit_err)
  );

  always #5 axis_clk = ~axis_clk;

  // Downstream ready: constant or alternating every cycle.
  always @(posedge axis_clk) begin
    #1;
    if (toggle_en) m_axis_tready = ~m_axis_tready;
    else           m_axis_tready = ready_val;
  end

  // Monitors: compare DUT output against the scoreboard queues.
  always @(negedge axis_clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (m_q.size() == 0) begin
        errors++;
        $display("FAIL m_axis_unexpected got data=%h expected no beat", m_axis_tdata);
      end else begin
        mon_b = m_q.pop_front();
        if (m_axis_tdata !== mon_b.data || m_axis_tkeep !== mon_b.keep || m_axis_tlast !== mon_b.last) begin
          errors++;
          $display("FAIL m_axis_beat got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast, mon_b.data, mon_b.keep, mon_b.last);
        end
      end
    end
    if (o_seg_wea) begin
      checks++;
      if (seg_q.size() == 0) begin
        errors++;
        $display("FAIL seg_unexpected got addr=%0d expected no write", o_seg_addra);
      end else begin
        mon_s = seg_q.pop_front();
        if (o_seg_addra !== mon_s.addr || o_seg_tdata !== mon_s.data) begin
          errors++;
          $display("FAIL seg_write got addr=%0d data=%h expected addr=%0d data=%h",
                   o_seg_addra, o_seg_tdata, mon_s.addr, mon_s.data);
        end
      end
    end
    if (o_wait_segs_end) begin
      pulse_cnt++;
      checks++;
      if (!(prev_wea === 1'b1 && prev_addr === 3'd7)) begin
        errors++;
        $display("FAIL pulse_timing got prev_wea=%b prev_addr=%0d expected prev_wea=1 prev_addr=7",
                 prev_wea, prev_addr);
      end
    end
    prev_wea  = o_seg_wea;
    prev_addr = o_seg_addra;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d, input logic [KW-1:0] k);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < KW; b++) if (k[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic push_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    m_q.push_back(b);
  endtask

  task automatic push_seg(input int a, input logic [DW-1:0] d);
    seg_t s;
    s.addr = 3'(a); s.data = d;
    seg_q.push_back(s);
  endtask

  // Present one beat and return one step after the edge that accepted it.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int t;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    t = 0;
    while (t < 100) begin
      @(negedge axis_clk);
      if (s_axis_tready) break;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_beat_timeout got tready=0 expected tready=1 within 100 cycles");
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send_packet(input int n, input logic [KW-1:0] last_keep);
    logic [DW-1:0] d [16];
    logic [KW-1:0] k;
    for (int i = 0; i < n; i++) d[i] = rand_data();
    for (int i = 0; i < n; i++) push_beat(d[i], (i == n - 1) ? last_keep : '1, i == n - 1);
    for (int a = 0; a < SN; a++) begin
      k = (a == n - 1) ? last_keep : '1;
      push_seg(a, (a < n) ? mask_bytes(d[a], k) : '0);
    end
    for (int i = 0; i < n; i++) send_beat(d[i], (i == n - 1) ? last_keep : '1, i == n - 1);
    s_axis_tvalid = 1'b0;
    $display("packet beats=%0d last_keep=%h driven", n, last_keep);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while ((seg_q.size() != 0 || m_q.size() != 0 || pulse_cnt < target) && t < 300) begin
      @(negedge axis_clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL drain_timeout got seg_left=%0d beats_left=%0d pulses=%0d expected 0 0 %0d",
               seg_q.size(), m_q.size(), pulse_cnt, target);
    end
    repeat (3) @(negedge axis_clk);
    checks++;
    if (pulse_cnt !== target) begin
      errors++;
      $display("FAIL pulse_count got %0d expected %0d", pulse_cnt, target);
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic pulse_done();
    i_parser_done = 1'b1;
    @(posedge axis_clk);
    #1;
    i_parser_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge axis_clk);
    checks++;
    if (o_seg_wea !== 1'b0 || o_wait_segs_end !== 1'b0 || m_axis_tvalid !== 1'b0 ||
        m_axis_tdata !== '0 || o_credits !== 2'd2 || o_credit_err !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got wea=%b pulse=%b mvalid=%b credits=%0d err=%b tready=%b expected 0 0 0 2 0 0",
               o_seg_wea, o_wait_segs_end, m_axis_tvalid, o_credits, o_credit_err, s_axis_tready);
    end
    #2 areset = 1'b0;
    @(negedge axis_clk);
    checks++;
    if (s_axis_tready !== 1'b1 || o_credits !== 2'd2) begin
      errors++;
      $display("FAIL idle_ready got tready=%b credits=%0d expected tready=1 credits=2",
               s_axis_tready, o_credits);
    end
    @(posedge axis_clk);
    #1;
    $display("reset done");
  endtask

  task automatic test_long_packet();
    int base;
    base = pulse_cnt;
    send_packet(10, '1);
    wait_done(base + 1);
    checks++;
    if (o_credits !== 2'd1) begin
      errors++;
      $display("FAIL long_credits got %0d expected 1", o_credits);
    end
    pulse_done();
    @(negedge axis_clk);
    checks++;
    if (o_credits !== 2'd2) begin
      errors++;
      $display("FAIL long_release got %0d expected 2", o_credits);
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_short_packet();
    int base;
    base = pulse_cnt;
    send_packet(3, 32'h0000FFFF);
    @(negedge axis_clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL pad_stall got tready=%b expected 0", s_axis_tready);
    end
    wait_done(base + 1);
    checks++;
    if (o_credits !== 2'd1) begin
      errors++;
      $display("FAIL short_credits got %0d expected 1", o_credits);
    end
    pulse_done();
  endtask

  task automatic test_credits();
    int base;
    logic [DW-1:0] d;
    base = pulse_cnt;
    send_packet(1, '1);
    send_packet(1, '1);
    wait_done(base + 2);
    checks++;
    if (o_credits !== 2'd0) begin
      errors++;
      $display("FAIL credits_exhausted got %0d expected 0", o_credits);
    end
    d = rand_data();
    push_beat(d, '1, 1'b1);
    for (int a = 0; a < SN; a++) push_seg(a, (a == 0) ? d : '0);
    s_axis_tdata  = d;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      checks++;
      if (s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL credit_stall got tready=%b expected 0 cycle=%0d", s_axis_tready, i);
      end
    end
    @(posedge axis_clk);
    #1;
    pulse_done();
    @(negedge axis_clk);
    checks++;
    if (s_axis_tready !== 1'b1 || o_credits !== 2'd1) begin
      errors++;
      $display("FAIL credit_resume got tready=%b credits=%0d expected tready=1 credits=1",
               s_axis_tready, o_credits);
    end
    @(posedge axis_clk);
    #1;
    s_axis_tvalid = 1'b0;
    $display("packet beats=1 third packet released");
    wait_done(base + 3);
    checks++;
    if (o_credits !== 2'd0) begin
      errors++;
      $display("FAIL credits_third got %0d expected 0", o_credits);
    end
  endtask

  task automatic test_coincident();
    int base;
    int t;
    pulse_done();
    base = pulse_cnt;
    send_packet(1, '1);
    t = 0;
    while (t < 100) begin
      @(negedge axis_clk);
      if (o_seg_wea === 1'b1 && o_seg_addra === 3'd7) break;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL addr7_timeout got no addr 7 write expected one");
    end
    i_parser_done = 1'b1;
    @(posedge axis_clk);
    #1;
    i_parser_done = 1'b0;
    wait_done(base + 1);
    checks++;
    if (o_credits !== 2'd1 || o_credit_err !== 1'b0) begin
      errors++;
      $display("FAIL coincident got credits=%0d err=%b expected credits=1 err=0", o_credits, o_credit_err);
    end
    pulse_done();
    pulse_done();
    @(negedge axis_clk);
    checks++;
    if (o_credits !== 2'd2 || o_credit_err !== 1'b1) begin
      errors++;
      $display("FAIL credit_overflow got credits=%0d err=%b expected credits=2 err=1", o_credits, o_credit_err);
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_backpressure();
    int base;
    base = pulse_cnt;
    toggle_en = 1'b1;
    send_packet(12, '1);
    wait_done(base + 1);
    toggle_en = 1'b0;
    ready_val = 1'b1;
    @(posedge axis_clk);
    #1;
    checks++;
    if (o_credits !== 2'd1) begin
      errors++;
      $display("FAIL backpressure_credits got %0d expected 1", o_credits);
    end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    int base;
    logic [DW-1:0] d [5];
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      d[i] = rand_data();
      push_beat(d[i], '1, 1'b0);
      push_seg(i, d[i]);
    end
    for (int i = 0; i < 5; i++) send_beat(d[i], '1, 1'b0);
    s_axis_tvalid = 1'b0;
    @(negedge axis_clk);
    checks++;
    if (o_seg_wea !== 1'b1 || o_seg_addra !== 3'd4) begin
      errors++;
      $display("FAIL addr4_write got wea=%b addr=%0d expected wea=1 addr=4", o_seg_wea, o_seg_addra);
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if (o_seg_wea !== 1'b0 || o_wait_segs_end !== 1'b0 || m_axis_tvalid !== 1'b0 ||
        o_credits !== 2'd2 || o_credit_err !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got wea=%b pulse=%b mvalid=%b credits=%0d err=%b tready=%b expected 0 0 0 2 0 0",
               o_seg_wea, o_wait_segs_end, m_axis_tvalid, o_credits, o_credit_err, s_axis_tready);
    end
    checks++;
    if (m_q.size() != 0 || seg_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending got beats=%0d segs=%0d expected 0 0", m_q.size(), seg_q.size());
    end
    repeat (2) @(negedge axis_clk);
    #2 areset = 1'b0;
    @(posedge axis_clk);
    #1;
    checks++;
    if (pulse_cnt !== base) begin
      errors++;
      $display("FAIL midreset_pulse got %0d expected %0d", pulse_cnt, base);
    end
    $display("packet beats=5 abandoned by reset");
    send_packet(2, '1);
    wait_done(base + 1);
    checks++;
    if (o_credits !== 2'd1) begin
      errors++;
      $display("FAIL after_reset_credits got %0d expected 1", o_credits);
    end
  endtask

  initial begin
    test_reset();
    test_long_packet();
    test_short_packet();
    test_credits();
    test_coincident();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
